// File: rtl/register_bank_swap_if.sv
// Command/bank interface for register_bank_swap: sequencer drives master, bank block is slave.
interface register_bank_swap_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [IDX_W-1:0]          cmd_a;
  logic [IDX_W-1:0]          cmd_b;
  logic [WIDTH-1:0]          cmd_data;
  logic [NUM_REGS*WIDTH-1:0] reg_out;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data,
    input  cmd_ready, reg_out, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data,
    output cmd_ready, reg_out, busy, done, err
  );
endinterface

// File: rtl/register_bank_swap.sv
// Register bank with indexed load, three-step XOR pair swap and whole-bank rotate.
// Optional saturating swap counter enabled by REGISTER_BANK_SWAP_COUNT_EN.
module register_bank_swap #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef REGISTER_BANK_SWAP_COUNT_EN
  output logic [15:0] swap_count,
`endif
  register_bank_swap_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W:0] REGS_LIM = (IDX_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {OP_LOAD, OP_SWAP, OP_ROTL, OP_ROTR} op_e;
  typedef enum logic [1:0] {S_IDLE, S_SW2, S_SW3} state_e;

  state_e                              state_q, state_d;
  logic [NUM_REGS-1:0][WIDTH-1:0]      bank_q, bank_d;
  logic [IDX_W-1:0]                    sa_q, sa_d, sb_q, sb_d;
  logic                                ready_q, busy_q;
  logic                                done_q, done_d, err_q, err_d;
  logic                                a_bad_c, b_bad_c;

  assign a_bad_c = ({1'b0, bus.cmd_a} >= REGS_LIM);
  assign b_bad_c = ({1'b0, bus.cmd_b} >= REGS_LIM);

  // Next-state, bank update and completion flags
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          done_d = 1'b1;
          unique case (op_e'(bus.cmd_op))
            OP_LOAD: begin
              if (a_bad_c) err_d = 1'b1;
              else         bank_d[bus.cmd_a] = bus.cmd_data;
            end
            OP_SWAP: begin
              if (a_bad_c || b_bad_c) begin
                err_d = 1'b1;
              end else if (bus.cmd_a != bus.cmd_b) begin
                bank_d[bus.cmd_a] = bank_q[bus.cmd_a] ^ bank_q[bus.cmd_b];
                sa_d    = bus.cmd_a;
                sb_d    = bus.cmd_b;
                state_d = S_SW2;
                done_d  = 1'b0;
              end
            end
            OP_ROTL: bank_d = {bank_q[NUM_REGS-2:0], bank_q[NUM_REGS-1]};
            OP_ROTR: bank_d = {bank_q[0], bank_q[NUM_REGS-1:1]};
            default: ;
          endcase
        end
      end
      S_SW2: begin
        bank_d[sb_q] = bank_q[sb_q] ^ bank_q[sa_q];
        state_d      = S_SW3;
      end
      S_SW3: begin
        bank_d[sa_q] = bank_q[sa_q] ^ bank_q[sb_q];
        state_d      = S_IDLE;
        done_d       = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ready/busy are registered copies of the upcoming state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.reg_out   = bank_q;

`ifdef REGISTER_BANK_SWAP_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts only genuine swaps, i.e. the final step of the XOR sequence
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SW3 && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign swap_count = cnt_q;
`endif

endmodule

// File: tb/tb_register_bank_swap.sv
// Randomized scoreboard bench for register_bank_swap (plus a NUM_REGS=3 instance for range errors).
module tb_register_bank_swap;
  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  register_bank_swap_if #(.WIDTH(W), .NUM_REGS(N)) bus ();
  register_bank_swap_if #(.WIDTH(W), .NUM_REGS(3)) bus3 ();

`ifdef REGISTER_BANK_SWAP_COUNT_EN
  logic [15:0] swap_count, swap_count3;
  register_bank_swap #(.WIDTH(W), .NUM_REGS(N)) dut (.clk(clk), .rst_n(rst_n), .swap_count(swap_count), .bus(bus));
  register_bank_swap #(.WIDTH(W), .NUM_REGS(3)) dut3 (.clk(clk), .rst_n(rst_n), .swap_count(swap_count3), .bus(bus3));
`else
  register_bank_swap #(.WIDTH(W), .NUM_REGS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  register_bank_swap #(.WIDTH(W), .NUM_REGS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
`endif

  typedef struct {
    logic [31:0] bank;
    logic        err;
    int unsigned cyc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m[N];
  logic [15:0] cnt_m = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_model();
    logic [31:0] p;
    for (int i = 0; i < N; i++) p[i*W +: W] = m[i];
    return p;
  endfunction

  // Reference semantics: plain exchange and modular rotation on an array
  function automatic void model_apply(input logic [1:0] op, input int a, input int b, input logic [7:0] d);
    exp_t       e;
    logic [7:0] t[N];
    int unsigned lat = 0;
    e.err = 1'b0;
    t = m;
    case (op)
      2'd0: if (a >= N) e.err = 1'b1; else m[a] = d;
      2'd1: begin
        if (a >= N || b >= N) e.err = 1'b1;
        else if (a != b) begin
          m[a] = t[b];
          m[b] = t[a];
          lat  = 2;
          if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end
      end
      2'd2: for (int i = 0; i < N; i++) m[(i + 1) % N] = t[i];
      default: for (int i = 0; i < N; i++) m[i] = t[(i + 1) % N];
    endcase
    e.bank = pack_model();
    e.cyc  = cyc + 1 + lat;
    e.cnt  = cnt_m;
    exp_q.push_back(e);
  endfunction

  // Called just after a falling edge; holds the command until accepted
  task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [7:0] d);
    bit acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_data  = d;
    for (int k = 0; k < 20 && !acc; k++) begin
      if (bus.cmd_ready) begin
        model_apply(op, int'(a), int'(b), d);
        acc = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every completion pops one expectation
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_vs_busy", 64'(bus.cmd_ready), 64'(!bus.busy));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(bus.done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("bank", 64'(bus.reg_out), 64'(e.bank));
          check("err", 64'(bus.err), 64'(e.err));
          check("busy_at_done", 64'(bus.busy), 64'd0);
`ifdef REGISTER_BANK_SWAP_COUNT_EN
          check("swap_count", 64'(swap_count), 64'(e.cnt));
`endif
        end
      end else if (bus.err) begin
        check("err_without_done", 64'(bus.err), 64'd0);
      end
    end
  end

  initial begin
    bus.cmd_valid  = 1'b0; bus.cmd_op  = '0; bus.cmd_a  = '0; bus.cmd_b  = '0; bus.cmd_data  = '0;
    bus3.cmd_valid = 1'b0; bus3.cmd_op = '0; bus3.cmd_a = '0; bus3.cmd_b = '0; bus3.cmd_data = '0;
    for (int i = 0; i < N; i++) m[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_reg_out", 64'(bus.reg_out), 64'h0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(2'd0, 2'd0, 2'd0, 8'h11);
    send(2'd0, 2'd1, 2'd0, 8'h22);
    send(2'd0, 2'd2, 2'd0, 8'h33);
    send(2'd0, 2'd3, 2'd0, 8'h44);
    check("ready_after_loads", 64'(bus.cmd_ready), 64'd1);
    drain();
    check("loaded_bank", 64'(bus.reg_out), 64'h44332211);

    send(2'd2, 2'd0, 2'd0, 8'h00);
    drain();
    check("rotl_bank", 64'(bus.reg_out), 64'h33221144);
    send(2'd3, 2'd0, 2'd0, 8'h00);
    drain();
    check("rotr_bank", 64'(bus.reg_out), 64'h44332211);

    send(2'd1, 2'd0, 2'd3, 8'h00);
    check("swap_busy", 64'(bus.busy), 64'd1);
    check("swap_not_ready", 64'(bus.cmd_ready), 64'd0);
    send(2'd2, 2'd0, 2'd0, 8'h00);
    drain();
    check("swap_then_rotl", 64'(bus.reg_out), 64'h33224411);
    send(2'd1, 2'd2, 2'd2, 8'h00);
    drain();

    for (int n = 0; n < 250; n++) begin
      logic [1:0] op, a, b;
      op = 2'($urandom_range(0, 3));
      a  = 2'($urandom_range(0, 3));
      b  = ($urandom_range(0, 4) == 0) ? a : 2'($urandom_range(0, 3));
      send(op, a, b, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // Asynchronous reset while the swap sequence sits in its last step
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_a = 2'd1; bus.cmd_b = 2'd2;
    check("pre_swap_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("sw3_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reg_out", 64'(bus.reg_out), 64'h0);
    check("async_ready", 64'(bus.cmd_ready), 64'd1);
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_done", 64'(bus.done), 64'd0);
`ifdef REGISTER_BANK_SWAP_COUNT_EN
    check("async_count", 64'(swap_count), 64'd0);
`endif
    for (int i = 0; i < N; i++) m[i] = '0;
    cnt_m = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'd0, 2'd1, 2'd0, 8'hA5);
    drain();
    check("post_reset_load", 64'(bus.reg_out[15:8]), 64'hA5);

    // Three-register instance: index 3 is out of range
    bus3.cmd_valid = 1'b1; bus3.cmd_op = 2'd0; bus3.cmd_a = 2'd2; bus3.cmd_data = 8'h5A;
    check("n3_ready", 64'(bus3.cmd_ready), 64'd1);
    @(negedge clk);
    check("n3_load_done", 64'(bus3.done), 64'd1);
    check("n3_load_err", 64'(bus3.err), 64'd0);
    check("n3_load_bank", 64'(bus3.reg_out), 64'h5A0000);
    bus3.cmd_a = 2'd3; bus3.cmd_data = 8'hFF;
    @(negedge clk);
    check("n3_bad_load_done", 64'(bus3.done), 64'd1);
    check("n3_bad_load_err", 64'(bus3.err), 64'd1);
    check("n3_bad_load_bank", 64'(bus3.reg_out), 64'h5A0000);
    bus3.cmd_op = 2'd1; bus3.cmd_a = 2'd0; bus3.cmd_b = 2'd3;
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    check("n3_bad_swap_err", 64'(bus3.err), 64'd1);
    check("n3_bad_swap_busy", 64'(bus3.busy), 64'd0);
    check("n3_bad_swap_bank", 64'(bus3.reg_out), 64'h5A0000);
    @(negedge clk);
    check("n3_done_cleared", 64'(bus3.done), 64'd0);
    check("n3_err_cleared", 64'(bus3.err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
